// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic matrix multiplier datapath.
// Holds the grid FSM encoding, default operand/accumulator widths and the lane slicing helper.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_OP_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH = 32;

    // Low bit of element idx in a flat vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary MAC processing element: forwards a right and b down, accumulates a*b.
// All registers hold unless advance is high; clear zeroes everything for the next product.
module systolic_pe #(
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        advance,
    input  logic                        clear,
    input  logic signed [OP_WIDTH-1:0]  a_in,
    input  logic signed [OP_WIDTH-1:0]  b_in,
    output logic [OP_WIDTH-1:0]         a_out,
    output logic [OP_WIDTH-1:0]         b_out,
    output logic [ACC_WIDTH-1:0]        acc
);

    logic signed [2*OP_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]         prod_ext;

    assign prod = a_in * b_in;
    // Signed size cast sign-extends or truncates; the sum wraps with no saturation.
    assign prod_ext = ACC_WIDTH'(prod);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clear) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (advance) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_mac_grid.sv
// N x N output-stationary MAC grid: accepts 2N-1 skewed wavefront beats, flushes N-1 cycles,
// then holds the result matrix on a valid/ready handshake until consumed.
module systolic_mac_grid
    import systolic_pkg::*;
#(
    parameter int N         = 2,
    parameter int OP_WIDTH  = DEF_OP_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*OP_WIDTH-1:0]      new_a_column,
    input  logic [N*OP_WIDTH-1:0]      new_b_row,
    output logic [N*N*ACC_WIDTH-1:0]   result,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic                       busy
);

    localparam int LAST_BEAT  = 2*N - 1;
    localparam int FLUSH_LAST = (N > 1) ? N - 2 : 0;
    localparam int CW         = $clog2(2*N) + 1;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          accept, advance, clear, flushing;

    // a_link[i][j] feeds PE(i,j) from the left; b_link[i][j] feeds it from above.
    logic [N-1:0][N:0][OP_WIDTH-1:0]   a_link;
    logic [N:0][N-1:0][OP_WIDTH-1:0]   b_link;
    logic [N-1:0][N-1:0][ACC_WIDTH-1:0] acc_grid;
    logic [N-1:0][OP_WIDTH-1:0]        a_tail;
    logic                              unused_edge;

    assign in_ready     = (state == IDLE) || (state == LOAD);
    assign flushing     = (state == FLUSH);
    assign accept       = in_valid && in_ready;
    assign advance      = accept || flushing;
    assign result_valid = (state == DONE);
    assign clear        = result_valid && result_ready;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // cnt counts accepted beats in LOAD and elapsed flush cycles in FLUSH.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LAST_BEAT == 1) begin
                        state_n = DONE;
                        cnt_n   = '0;
                    end else begin
                        state_n = LOAD;
                        cnt_n   = CW'(1);
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    if (cnt == CW'(LAST_BEAT - 1)) begin
                        state_n = (N == 1) ? DONE : FLUSH;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (cnt == CW'(FLUSH_LAST)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    genvar i, j;
    generate
        for (i = 0; i < N; i++) begin : g_edge
            // Zero the grid edges while flushing so only in-flight operands accumulate.
            assign a_link[i][0] = flushing ? '0 : new_a_column[slice_lo(i, OP_WIDTH) +: OP_WIDTH];
            assign b_link[0][i] = flushing ? '0 : new_b_row[slice_lo(i, OP_WIDTH) +: OP_WIDTH];
            assign a_tail[i]    = a_link[i][N];
        end

        for (i = 0; i < N; i++) begin : g_row
            for (j = 0; j < N; j++) begin : g_col
                systolic_pe #(
                    .OP_WIDTH (OP_WIDTH),
                    .ACC_WIDTH(ACC_WIDTH)
                ) u_pe (
                    .clk    (clk),
                    .reset_n(reset_n),
                    .advance(advance),
                    .clear  (clear),
                    .a_in   (a_link[i][j]),
                    .b_in   (b_link[i][j]),
                    .a_out  (a_link[i][j+1]),
                    .b_out  (b_link[i+1][j]),
                    .acc    (acc_grid[i][j])
                );
                assign result[slice_lo(i*N + j, ACC_WIDTH) +: ACC_WIDTH] = acc_grid[i][j];
            end
        end
    endgenerate

    // Operands leaving the far edges of the grid are dropped.
    assign unused_edge = ^{a_tail, b_link[N]};

endmodule

// File: tb/tb_systolic_mac_grid.sv
// Scoreboard bench for systolic_mac_grid: N=2 with a 32-bit and a 16-bit accumulator copy
// driven by identical stimulus; expected matrices come from a software matrix product.
module tb_systolic_mac_grid;

    localparam int TN   = 2;
    localparam int OPW  = 8;
    localparam int AW   = 32;
    localparam int AW16 = 16;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   in_valid;
    logic                   result_ready;
    logic [TN*OPW-1:0]      new_a_column;
    logic [TN*OPW-1:0]      new_b_row;
    logic                   in_ready, result_valid, busy;
    logic                   in_ready16, result_valid16, busy16;
    logic [TN*TN*AW-1:0]    result32;
    logic [TN*TN*AW16-1:0]  result16;

    int total = 0;
    int bad   = 0;
    int ma[TN][TN];
    int mb[TN][TN];
    logic [TN*TN*AW-1:0] sb_q[$];

    always #5 clk = ~clk;

    systolic_mac_grid #(.N(TN), .OP_WIDTH(OPW), .ACC_WIDTH(AW)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .new_a_column(new_a_column), .new_b_row(new_b_row), .result(result32),
        .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
    );

    systolic_mac_grid #(.N(TN), .OP_WIDTH(OPW), .ACC_WIDTH(AW16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready16),
        .new_a_column(new_a_column), .new_b_row(new_b_row), .result(result16),
        .result_valid(result_valid16), .result_ready(result_ready), .busy(busy16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_model();
        logic [TN*TN*AW-1:0] e;
        int s;
        e = '0;
        for (int i = 0; i < TN; i++)
            for (int j = 0; j < TN; j++) begin
                s = 0;
                for (int k = 0; k < TN; k++) s += ma[i][k] * mb[k][j];
                e[(i*TN+j)*AW +: AW] = s;
            end
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge right after the last beat's accepting edge.
    task automatic send(input int nbeats, input int gap);
        for (int t = 0; t < nbeats; t++) begin
            in_valid = 1'b1;
            new_a_column = '0;
            new_b_row = '0;
            for (int i = 0; i < TN; i++) begin
                if (t - i >= 0 && t - i < TN) begin
                    new_a_column[i*OPW +: OPW] = OPW'(ma[i][t-i]);
                    new_b_row[i*OPW +: OPW]    = OPW'(mb[t-i][i]);
                end
            end
            @(negedge clk);
            if (gap > 0 && t < nbeats - 1) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        in_valid = 1'b0;
        new_a_column = '0;
        new_b_row = '0;
    endtask

    task automatic get_result();
        logic [TN*TN*AW-1:0] e;
        int lat;
        lat = 0;
        while (!result_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, TN - 1);
        chk("rv16", result_valid16, 1);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            for (int i = 0; i < TN*TN; i++) begin
                chk($sformatf("c32_%0d", i), result32[i*AW +: AW], e[i*AW +: AW]);
                chk($sformatf("c16_%0d", i), result16[i*AW16 +: AW16], e[i*AW +: AW16]);
            end
        end
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdy"}, in_ready, 1);
        chk({tag, "_res0"}, result32 == '0, 1);
        chk({tag, "_res16"}, result16 == '0, 1);
    endtask

    task automatic set_basic();
        ma = '{'{1, 2}, '{3, 4}};
        mb = '{'{5, 6}, '{7, 8}};
    endtask

    logic [TN*TN*AW-1:0] snap;

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        result_ready = 1'b1;
        new_a_column = '0;
        new_b_row = '0;
        repeat (2) @(negedge clk);
        idle_check("reset");
        chk("reset_busy16", busy16, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic product, back-to-back beats
        set_basic();
        push_model();
        send(2*TN - 1, 0);
        chk("flush_rv", result_valid, 0);
        get_result();
        @(negedge clk);
        idle_check("basic_post");

        // Signed operands
        ma = '{'{-1, -1}, '{-1, -1}};
        mb = '{'{127, 127}, '{127, 127}};
        push_model();
        send(2*TN - 1, 0);
        get_result();
        @(negedge clk);
        idle_check("signed_post");

        // Gapped input
        set_basic();
        push_model();
        send(2*TN - 1, 3);
        get_result();
        @(negedge clk);

        // Backpressure with ignored beats, then a product that relies on the clear
        result_ready = 1'b0;
        ma = '{'{2, -3}, '{5, 7}};
        mb = '{'{-4, 6}, '{1, 9}};
        push_model();
        send(2*TN - 1, 0);
        get_result();
        snap = result32;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            new_a_column = {TN{8'h11}};
            new_b_row = {TN{8'h22}};
            @(negedge clk);
            chk("bp_rdy", in_ready, 0);
            chk("bp_rv", result_valid, 1);
            chk("bp_hold", result32 == snap, 1);
        end
        result_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        new_a_column = '0;
        new_b_row = '0;
        idle_check("hs_post");
        ma = '{'{1, 0}, '{0, 1}};
        mb = '{'{9, 8}, '{7, 6}};
        push_model();
        send(2*TN - 1, 0);
        get_result();
        @(negedge clk);

        // Reset mid-operation discards the partial product
        set_basic();
        send(2, 0);
        chk("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        idle_check("areset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_basic();
        push_model();
        send(2*TN - 1, 0);
        get_result();
        @(negedge clk);

        // Wrap: 16-bit copy reaches 0x8000 without saturating
        ma = '{'{-128, -128}, '{-128, -128}};
        mb = '{'{-128, -128}, '{-128, -128}};
        push_model();
        send(2*TN - 1, 0);
        get_result();
        chk("wrap16", result16[AW16-1:0], 16'h8000);
        @(negedge clk);

        chk("sb_left", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
